// File: rtl/alu_mul_sequencer.sv
// Multi-cycle controller in front of a 32-bit ALU: runs shift-add unsigned
// multiplies through the ALU ADD op, or issues a single pass-through ALU op.
module alu_mul_sequencer #(
  parameter logic EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [2:0]  req_ctrl,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_STEP = 2'd1,
    PASS     = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [31:0] acc;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [5:0]  step_cnt;
  logic [2:0]  op_ctrl;
  logic        mul_done;

  assign mul_done = (step_cnt == 6'd32) || (EARLY_EXIT && (mplier == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_ctrl   = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_op ? PASS : MUL_STEP;
      end
      MUL_STEP: begin
        alu_a    = acc;
        alu_b    = mcand;
        alu_ctrl = 4'b0010;
        if (mul_done) state_next = DONE;
      end
      PASS: begin
        alu_a      = acc;
        alu_b      = mcand;
        alu_ctrl   = {1'b0, op_ctrl};
        state_next = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A PASS op parks its operands in acc/mcand, which feed the ALU in both busy states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      step_cnt   <= '0;
      op_ctrl    <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (!req_op) begin
              acc      <= '0;
              mcand    <= req_a;
              mplier   <= req_b;
              step_cnt <= '0;
            end else begin
              acc     <= req_a;
              mcand   <= req_b;
              op_ctrl <= req_ctrl;
            end
          end
        end
        MUL_STEP: begin
          if (mul_done) begin
            rsp_result <= acc;
            rsp_zero   <= (acc == '0);
          end else begin
            if (mplier[0]) acc <= alu_result;
            mcand    <= {mcand[30:0], 1'b0};
            mplier   <= {1'b0, mplier[31:1]};
            step_cnt <= step_cnt + 6'd1;
          end
        end
        PASS: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench: two sequencers (EARLY_EXIT=0 and 1), each with a behavioural
// ALU; expected results/latencies are queued at accept and checked by a monitor.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_op    [2];
  logic [2:0]  req_ctrl  [2];
  logic [31:0] req_a     [2];
  logic [31:0] req_b     [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_result[2];
  logic        rsp_zero  [2];
  logic [31:0] alu_a     [2];
  logic [31:0] alu_b     [2];
  logic [3:0]  alu_ctrl  [2];
  logic [31:0] alu_result[2];
  logic        alu_zero  [2];

  typedef struct {
    logic [31:0] res;
    logic        zero;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic        cur_op  [2];
  logic [2:0]  cur_ctrl[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result[0] = alu_f(alu_ctrl[0], alu_a[0], alu_b[0]);
  assign alu_result[1] = alu_f(alu_ctrl[1], alu_a[1], alu_b[1]);
  assign alu_zero[0]   = (alu_result[0] == 32'd0);
  assign alu_zero[1]   = (alu_result[1] == 32'd0);

  alu_mul_sequencer #(.EARLY_EXIT(1'b0)) u_full (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
    .req_ctrl(req_ctrl[0]), .req_a(req_a[0]), .req_b(req_b[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_result(rsp_result[0]), .rsp_zero(rsp_zero[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_ctrl(alu_ctrl[0]),
    .alu_result(alu_result[0]), .alu_zero(alu_zero[0])
  );

  alu_mul_sequencer #(.EARLY_EXIT(1'b1)) u_early (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
    .req_ctrl(req_ctrl[1]), .req_a(req_a[1]), .req_b(req_b[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_result(rsp_result[1]), .rsp_zero(rsp_zero[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_ctrl(alu_ctrl[1]),
    .alu_result(alu_result[1]), .alu_zero(alu_zero[1])
  );

  // Reference: product mod 2^32 or the ALU op; latency from the multiplier's bit length.
  function automatic logic [31:0] ref_res(input logic op, input logic [2:0] ctrl,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (op) return alu_f({1'b0, ctrl}, a, b);
    p = {32'd0, a} * {32'd0, b};
    return p[31:0];
  endfunction

  function automatic int ref_lat(input int k, input logic op, input logic [31:0] b);
    int n = 0;
    if (op) return 2;
    if (k == 0) return 34;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return n + 2;
  endfunction

  function automatic int qsz(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic push_exp(input int k, input logic op, input logic [2:0] ctrl,
                          input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.res  = ref_res(op, ctrl, a, b);
    e.zero = (e.res == 32'd0);
    e.due  = cyc + ref_lat(k, op, b) - 1;
    cur_op[k]   = op;
    cur_ctrl[k] = ctrl;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input int k, input logic op, input logic [2:0] ctrl,
                       input logic [31:0] a, input logic [31:0] b);
    logic rdy;
    int   waited = 0;
    req_valid[k] = 1'b1;
    req_op[k]    = op;
    req_ctrl[k]  = ctrl;
    req_a[k]     = a;
    req_b[k]     = b;
    do begin
      @(negedge clk);
      rdy = req_ready[k];
      @(posedge clk);
      waited++;
    end while (!rdy && waited < 300);
    #1;
    if (!rdy) chk1("accept_timeout", 1'b0, 1'b1);
    else      push_exp(k, op, ctrl, a, b);
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    logic ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (req_ready[k] && qsz(k) == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk1("drain", ok, 1'b1);
  endtask

  // Monitor: pops on the first cycle of each response, checks hold while stalled,
  // and checks ALU drive against the op in flight.
  initial begin
    exp_t        e;
    logic        seen[2];
    logic [31:0] held[2];
    seen[0] = 1'b0;
    seen[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen[0] = 1'b0;
        seen[1] = 1'b0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (req_ready[k] || rsp_valid[k]) begin
            chk("alu_a_quiet", alu_a[k], 32'd0);
            chk("alu_b_quiet", alu_b[k], 32'd0);
            chk("alu_ctrl_quiet", {28'd0, alu_ctrl[k]}, 32'd0);
          end else begin
            chk("alu_ctrl_busy", {28'd0, alu_ctrl[k]},
                cur_op[k] ? {29'd0, cur_ctrl[k]} : 32'd2);
          end
          if (rsp_valid[k] && !seen[k]) begin
            seen[k] = 1'b1;
            held[k] = rsp_result[k];
            if (qsz(k) == 0) begin
              chk1("unexpected_rsp", 1'b1, 1'b0);
            end else begin
              e = (k == 0) ? q0.pop_front() : q1.pop_front();
              chk("rsp_result", rsp_result[k], e.res);
              chk1("rsp_zero", rsp_zero[k], e.zero);
              chk("latency_cycle", 32'(cyc), 32'(e.due));
            end
          end else if (rsp_valid[k]) begin
            chk("rsp_hold", rsp_result[k], held[k]);
          end
          if (rsp_valid[k] && rsp_ready[k]) seen[k] = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic        op;
    logic [2:0]  ctrl;
    logic [31:0] a, b;
    int          wt;
    logic        rnd_done;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_op[k] = 1'b0; req_ctrl[k] = '0;
      req_a[k] = '0; req_b[k] = '0; rsp_ready[k] = 1'b1;
      cur_op[k] = 1'b0; cur_ctrl[k] = '0;
    end
    rst_n = 1'b0;
    #3;
    for (int k = 0; k < 2; k++) begin
      chk1("rst_req_ready", req_ready[k], 1'b1);
      chk1("rst_rsp_valid", rsp_valid[k], 1'b0);
      chk("rst_rsp_result", rsp_result[k], 32'd0);
      chk1("rst_rsp_zero", rsp_zero[k], 1'b0);
      chk("rst_alu_a", alu_a[k], 32'd0);
      chk("rst_alu_b", alu_b[k], 32'd0);
      chk("rst_alu_ctrl", {28'd0, alu_ctrl[k]}, 32'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed, early-exit instance
    issue(1, 1'b0, 3'b000, 32'd7, 32'd6);
    issue(1, 1'b0, 3'b000, 32'h12345678, 32'd0);
    issue(1, 1'b0, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int c = 0; c < 8; c++) issue(1, 1'b1, 3'(c), 32'd5, 32'd7);
    issue(1, 1'b1, 3'b111, 32'hFFFFFFFB, 32'd3);
    issue(1, 1'b0, 3'b000, 32'h80000000, 32'h80000000);
    // Directed, full-length instance
    issue(0, 1'b0, 3'b000, 32'd3, 32'd5);
    issue(0, 1'b0, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(0, 1'b0, 3'b000, 32'hDEADBEEF, 32'd0);
    issue(0, 1'b1, 3'b110, 32'd5, 32'd7);
    wait_idle(0);
    wait_idle(1);

    // Random traffic on both instances with random response backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          op = 1'($urandom_range(0, 1)); ctrl = 3'($urandom_range(0, 7));
          a = $urandom; b = $urandom >> $urandom_range(0, 32);
          issue(0, op, ctrl, a, b);
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          op = 1'($urandom_range(0, 1)); ctrl = 3'($urandom_range(0, 7));
          a = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
          b = $urandom >> $urandom_range(0, 32);
          issue(1, op, ctrl, a, b);
        end
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          rsp_ready[0] = ($urandom_range(0, 3) != 0);
          rsp_ready[1] = ($urandom_range(0, 3) != 0);
          if (cyc > 4000) rnd_done = 1'b1;
        end
        rsp_ready[0] = 1'b1;
        rsp_ready[1] = 1'b1;
      end
    join_any
    wait_idle(0);
    wait_idle(1);
    rnd_done = 1'b1;
    wait fork;
    #1;
    rsp_ready[0] = 1'b1;
    rsp_ready[1] = 1'b1;
    wait_idle(0);
    wait_idle(1);

    // Held response with a competing request pending
    rsp_ready[1] = 1'b0;
    issue(1, 1'b0, 3'b000, 32'd1000, 32'd3);
    wt = 0;
    while (!rsp_valid[1] && wt < 100) begin
      @(posedge clk);
      #1;
      wt++;
    end
    chk1("bp_valid_seen", rsp_valid[1], 1'b1);
    req_valid[1] = 1'b1; req_op[1] = 1'b1; req_ctrl[1] = 3'b001;
    req_a[1] = 32'h0F0F0000; req_b[1] = 32'h000000F0;
    repeat (10) begin
      @(negedge clk);
      chk1("bp_rsp_valid", rsp_valid[1], 1'b1);
      chk1("bp_req_ready", req_ready[1], 1'b0);
      chk("bp_result", rsp_result[1], 32'd3000);
    end
    @(posedge clk);
    #1 rsp_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    chk1("bp_idle_after_hs", req_ready[1], 1'b1);
    @(posedge clk);
    #1;
    chk1("bp_accepted_next", req_ready[1], 1'b0);
    if (!req_ready[1]) push_exp(1, 1'b1, 3'b001, 32'h0F0F0000, 32'h000000F0);
    req_valid[1] = 1'b0;
    wait_idle(1);

    // Asynchronous reset in the middle of a multiply
    issue(1, 1'b0, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1("arst_rsp_valid", rsp_valid[1], 1'b0);
    chk1("arst_req_ready", req_ready[1], 1'b1);
    chk("arst_alu_a", alu_a[1], 32'd0);
    chk("arst_alu_b", alu_b[1], 32'd0);
    chk("arst_alu_ctrl", {28'd0, alu_ctrl[1]}, 32'd0);
    q1.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk1("arst_ready_after", req_ready[1], 1'b1);
    issue(1, 1'b0, 3'b000, 32'd9, 32'd9);
    wait_idle(1);
    wait_idle(0);

    chk("leftover_q0", 32'(q0.size()), 32'd0);
    chk("leftover_q1", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that owns one 32-bit ALU instance and drives its a, b and alu_control inputs.
- Accepts requests over a valid/ready handshake. Each request is either:
  - a 32x32 unsigned shift-add multiply (low 32 bits of the product), using the ALU ADD op, or
  - a single ALU pass-through op.
- Returns the result over a valid/ready response handshake.
- Sits between the issue stage and the ALU in the datapath.

Parameters:
- EARLY_EXIT, 1, 1 = end the multiply as soon as the remaining multiplier is 0; 0 = always run 32 steps.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_op  in  1  0 = MUL, 1 = PASS.
- req_ctrl  in  3  ALU op for PASS: 000 AND, 001 OR, 010 ADD, 011 XOR, 110 SUB, 111 SLT, 100/101 reserved (ALU returns 0).
- req_a  in  32  operand A (multiplicand for MUL).
- req_b  in  32  operand B (multiplier for MUL).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_result  out  32  result.
- rsp_zero  out  1  rsp_result == 0.
- alu_a  out  32  to ALU a.
- alu_b  out  32  to ALU b.
- alu_ctrl  out  4  to ALU alu_control; bit 3 is always 0.
- alu_result  in  32  from ALU result.
- alu_zero  in  1  from ALU zero; unused for MUL.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - acc, mcand, mplier, step_cnt, rsp_result = 0.
  - rsp_zero = 0.
  - Outputs: req_ready = 1 (after reset), rsp_valid = 0, alu_a = alu_b = 0, alu_ctrl = 0.
  - Reset mid-operation aborts the operation; no response is produced.
- States: IDLE, MUL_STEP, PASS, DONE.
- IDLE:
  - Transaction accepted when req_valid && req_ready at a rising edge.
  - MUL: acc <= 0, mcand <= req_a, mplier <= req_b, step_cnt <= 0, go to MUL_STEP.
  - PASS: latch req_a, req_b, req_ctrl, go to PASS.
- MUL_STEP:
  - alu_a = acc, alu_b = mcand, alu_ctrl = 4'b0010 (combinational from registers).
  - Terminate condition: step_cnt == 32, or (EARLY_EXIT && mplier == 0).
  - If terminating: rsp_result <= acc, rsp_zero <= (acc == 0), go to DONE.
  - Otherwise, each edge:
    - if mplier[0], acc <= alu_result;
    - mcand <= mcand << 1 (logical);
    - mplier <= mplier >> 1 (logical);
    - step_cnt <= step_cnt + 1 (6-bit).
  - Arithmetic is mod 2^32; bits shifted out of mcand and ALU carries are discarded.
- PASS:
  - alu_a = latched A, alu_b = latched B, alu_ctrl = {1'b0, latched ctrl}.
  - Next edge: rsp_result <= alu_result, rsp_zero <= alu_zero, go to DONE.
- DONE:
  - rsp_valid = 1; result and zero are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE.
  - req_ready stays 0 until IDLE is reached, so there is no same-cycle accept on completion.
  - ALU outputs are driven to 0 in IDLE and DONE.
- Latency, counted in edges from the accept edge until rsp_valid is high:
  - PASS: 2.
  - MUL, EARLY_EXIT=1: N+2, where N = index of the highest set bit of B + 1 (N = 0 for B = 0).
  - MUL, EARLY_EXIT=0: always 34.
- Boundary conditions:
  - req_valid while busy: ignored; the requester must hold the request.
  - Reserved ctrl 100/101: result 0, zero = 1.
  - step_cnt never exceeds 32.
  - rsp_ready high while not in DONE: no effect.

Test Plan:
- MUL 7 x 6, EARLY_EXIT=1 -> rsp_result = 42, rsp_zero = 0, rsp_valid 5 edges after accept; alu_ctrl = 0010 during MUL_STEP.
- MUL 0x12345678 x 0 -> rsp_result = 0, rsp_zero = 1, rsp_valid 2 edges after accept.
- MUL 0xFFFFFFFF x 0xFFFFFFFF -> rsp_result = 0x00000001 (wrap), latency 34; repeat 3 x 5 with EARLY_EXIT=0 -> 15, latency 34.
- PASS sweep with A = 5, B = 7:
  - SUB -> 0xFFFFFFFE.
  - SLT -> 1.
  - XOR -> 2.
  - ctrl 101 -> 0, zero = 1.
  - Each has latency 2, and alu_ctrl[3] = 0 throughout.
- Backpressure: rsp_ready low 10 cycles in DONE -> rsp_valid and rsp_result stable, req_ready = 0, a new req_valid is not accepted; it is accepted 1 cycle after the rsp handshake.
- rst_n pulsed low mid-MUL (step 5 of 32) -> asynchronously: rsp_valid = 0, req_ready = 1 after release, all ALU outputs 0; the next MUL 9 x 9 returns 81.
